// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the priority interrupt controller.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PENDING   = 3'd0;
    localparam logic [2:0] IRQ_ENABLE    = 3'd1;
    localparam logic [2:0] IRQ_EDGE      = 3'd2;
    localparam logic [2:0] IRQ_ACTIVE    = 3'd3;
    localparam logic [2:0] IRQ_CLAIM     = 3'd4;
    localparam logic [2:0] IRQ_EOI       = 3'd5;
    localparam logic [2:0] IRQ_INSERVICE = 3'd6;
    localparam logic [2:0] IRQ_CONTROL   = 3'd7;

    typedef logic [7:0] irq_vec_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } irq_sel_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  irq_vec_t vec,
    output irq_sel_t sel
);

    always_comb begin
        sel = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                sel.valid = 1'b1;
                sel.id    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// 8-source priority interrupt controller driving the 6502 IRQB line.
// All state updates on the falling clock edge so CPU writes land in-cycle.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      i_data,
    output logic [7:0]      o_data,
    input  logic            cs,
    input  logic            rwb,
    input  logic [2:0]      addr,
    input  logic [NSRC-1:0] irq_src,
    output logic            irqb
);

    localparam irq_vec_t SRC_MASK = irq_vec_t'((16'd1 << NSRC) - 16'd1);

    irq_vec_t src_ext;
    irq_vec_t synced;
    irq_vec_t pending_q, pending_d;
    irq_vec_t enable_q, enable_d;
    irq_vec_t edge_q, edge_d;
    irq_vec_t inservice_q, inservice_d;
    irq_vec_t dly_q;
    logic     ctrl_q, ctrl_d;
    logic     irqb_q, irqb_d;

    irq_vec_t pend_en;
    irq_sel_t best;
    irq_sel_t isr;
    logic     act_valid;
    logic [3:0] top_isr;

    irq_vec_t w1c_vec, claim_vec, eoi_vec, rise;
    logic     wr_en;

    assign src_ext = irq_vec_t'(irq_src);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = src_ext;
        end else begin : g_sync
            irq_vec_t sync_q [SYNC_STAGES];
            always_ff @(negedge clk) begin
                if (reset) begin
                    for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= src_ext;
                    for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign synced = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign pend_en = pending_q & enable_q;

    irq_prio_enc u_best_enc (
        .vec (pend_en),
        .sel (best)
    );

    irq_prio_enc u_isr_enc (
        .vec (inservice_q),
        .sel (isr)
    );

    always_comb begin
        top_isr   = isr.valid ? {1'b0, isr.id} : 4'd8;
        act_valid = best.valid && ({1'b0, best.id} < top_isr);
        irqb_d    = ~(ctrl_q & act_valid);
    end

    always_comb begin
        wr_en     = cs & ~rwb;
        w1c_vec   = '0;
        claim_vec = '0;
        eoi_vec   = '0;
        enable_d  = enable_q;
        edge_d    = edge_q;
        ctrl_d    = ctrl_q;

        if (wr_en) begin
            case (addr)
                IRQ_PENDING: w1c_vec  = i_data;
                IRQ_ENABLE:  enable_d = i_data & SRC_MASK;
                IRQ_EDGE:    edge_d   = i_data & SRC_MASK;
                IRQ_CLAIM: begin
                    if (pend_en[i_data[2:0]]) claim_vec = irq_vec_t'(8'd1 << i_data[2:0]);
                end
                IRQ_EOI:     eoi_vec  = irq_vec_t'(8'd1 << i_data[2:0]);
                IRQ_CONTROL: ctrl_d   = i_data[0];
                default: ;
            endcase
        end

        // A fresh edge outranks W1C/CLAIM on the same bit so no request is lost.
        rise        = synced & ~dly_q;
        pending_d   = ((edge_q & ((pending_q & ~w1c_vec & ~claim_vec) | rise)) |
                       (~edge_q & synced)) & SRC_MASK;
        inservice_d = (inservice_q | claim_vec) & ~eoi_vec & SRC_MASK;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            enable_q    <= '0;
            edge_q      <= '0;
            inservice_q <= '0;
            dly_q       <= '0;
            ctrl_q      <= 1'b0;
            irqb_q      <= 1'b1;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_q      <= edge_d;
            inservice_q <= inservice_d;
            dly_q       <= synced;
            ctrl_q      <= ctrl_d;
            irqb_q      <= irqb_d;
        end
    end

    assign irqb = irqb_q;

    always_comb begin
        o_data = 8'h00;
        case (addr)
            IRQ_PENDING:   o_data = pending_q;
            IRQ_ENABLE:    o_data = enable_q;
            IRQ_EDGE:      o_data = edge_q;
            IRQ_ACTIVE:    o_data = act_valid ? {1'b1, 4'b0000, best.id} : 8'h00;
            IRQ_INSERVICE: o_data = inservice_q;
            IRQ_CONTROL:   o_data = {7'b0000000, ctrl_q};
            default:       o_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus queues expectations, a monitor checks them.
module tb_irq_controller;
    import irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_data;
    logic       rwb;
    logic [2:0] addr;
    logic       cs, cs4;
    logic [7:0] src;
    logic [3:0] src4;
    logic [7:0] o_data, o_data4;
    logic       irqb, irqb4;

    always #5 clk = ~clk;

    irq_controller #(
        .NSRC        (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .o_data  (o_data),
        .cs      (cs),
        .rwb     (rwb),
        .addr    (addr),
        .irq_src (src),
        .irqb    (irqb)
    );

    irq_controller #(
        .NSRC        (4),
        .SYNC_STAGES (0)
    ) dut4 (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .o_data  (o_data4),
        .cs      (cs4),
        .rwb     (rwb),
        .addr    (addr),
        .irq_src (src4),
        .irqb    (irqb4)
    );

    // kind: 0 = dut o_data, 1 = dut irqb, 2 = dut4 o_data, 3 = dut4 irqb
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] exp;
    } item_t;

    item_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    item_t      mon_it;
    string      mon_n;
    logic [7:0] mon_act;

    always @(posedge clk) begin
        while (exp_q.size() > 0) begin
            mon_it = exp_q.pop_front();
            mon_n  = name_q.pop_front();
            case (mon_it.kind)
                2'd0:    mon_act = o_data;
                2'd1:    mon_act = {7'b0, irqb};
                2'd2:    mon_act = o_data4;
                default: mon_act = {7'b0, irqb4};
            endcase
            checks++;
            if (mon_act !== mon_it.exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", mon_n, mon_act, mon_it.exp);
            end
        end
    end

    task automatic push(input logic [1:0] k, input logic [7:0] e, input string n);
        item_t it;
        it.kind = k;
        it.exp  = e;
        exp_q.push_back(it);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cs  = 1'b0;
        cs4 = 1'b0;
        rwb = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; cs4 = 1'b0; rwb = 1'b0; addr = a; i_data = d;
        tick();
        cs = 1'b0; rwb = 1'b1;
    endtask

    task automatic wr4(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b0; cs4 = 1'b1; rwb = 1'b0; addr = a; i_data = d;
        tick();
        cs4 = 1'b0; rwb = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
        cs = 1'b1; cs4 = 1'b0; rwb = 1'b1; addr = a;
        push(2'd0, e, n);
        tick();
        cs = 1'b0;
    endtask

    task automatic rd4(input logic [2:0] a, input logic [7:0] e, input string n);
        cs = 1'b0; cs4 = 1'b1; rwb = 1'b1; addr = a;
        push(2'd2, e, n);
        tick();
        cs4 = 1'b0;
    endtask

    task automatic exp_irq(input logic e, input string n);
        push(2'd1, {7'b0, e}, n);
    endtask

    task automatic exp_irq4(input logic e, input string n);
        push(2'd3, {7'b0, e}, n);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b0; cs4 = 1'b0; rwb = 1'b1; addr = '0; i_data = '0;
        src = '0; src4 = '0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: reset discards live state
        wr(IRQ_ENABLE, 8'hFF);
        wr(IRQ_CONTROL, 8'h01);
        src = 8'h80;
        repeat (4) idle();
        exp_irq(1'b0, "t1_irqb_live");
        rd(IRQ_PENDING, 8'h80, "t1_pend_live");
        reset = 1'b1; src = 8'h00;
        idle();
        reset = 1'b0;
        exp_irq(1'b1, "t1_irqb_reset");
        rd(IRQ_PENDING,   8'h00, "t1_pend_reset");
        rd(IRQ_ENABLE,    8'h00, "t1_en_reset");
        rd(IRQ_EDGE,      8'h00, "t1_edge_reset");
        rd(IRQ_ACTIVE,    8'h00, "t1_act_reset");
        rd(IRQ_INSERVICE, 8'h00, "t1_isr_reset");
        rd(IRQ_CONTROL,   8'h00, "t1_ctrl_reset");

        // 2: edge latency with two sync stages
        wr(IRQ_EDGE, 8'h01);
        wr(IRQ_ENABLE, 8'h01);
        wr(IRQ_CONTROL, 8'h01);
        src = 8'h01;
        idle();
        src = 8'h00;
        exp_irq(1'b1, "t2_irqb_e2");
        rd(IRQ_PENDING, 8'h00, "t2_pend_e2");
        rd(IRQ_PENDING, 8'h00, "t2_pend_e3");
        exp_irq(1'b1, "t2_irqb_e4");
        rd(IRQ_PENDING, 8'h01, "t2_pend_set");
        exp_irq(1'b0, "t2_irqb_low");
        rd(IRQ_ACTIVE, 8'h80, "t2_active");
        wr(IRQ_CLAIM, 8'h00);
        exp_irq(1'b0, "t2_irqb_claim_lag");
        rd(IRQ_PENDING, 8'h00, "t2_pend_claimed");
        exp_irq(1'b1, "t2_irqb_claimed");
        rd(IRQ_INSERVICE, 8'h01, "t2_isr_claimed");
        wr(IRQ_EOI, 8'h00);
        rd(IRQ_INSERVICE, 8'h00, "t2_isr_eoi");
        rd(IRQ_ACTIVE, 8'h00, "t2_active_idle");

        // 3: priority and nesting
        wr(IRQ_EDGE, 8'h02);
        wr(IRQ_ENABLE, 8'hFF);
        src = 8'h08;
        repeat (3) idle();
        rd(IRQ_PENDING, 8'h08, "t3_pend_lvl3");
        exp_irq(1'b0, "t3_irqb_src3");
        rd(IRQ_ACTIVE, 8'h83, "t3_active3");
        wr(IRQ_CLAIM, 8'h03);
        rd(IRQ_INSERVICE, 8'h08, "t3_isr3");
        exp_irq(1'b1, "t3_irqb_in_isr3");
        rd(IRQ_ACTIVE, 8'h00, "t3_active_blocked");
        src = 8'h0A;
        repeat (3) idle();
        exp_irq(1'b1, "t3_irqb_pre_preempt");
        rd(IRQ_PENDING, 8'h0A, "t3_pend_src1");
        exp_irq(1'b0, "t3_irqb_preempt");
        rd(IRQ_ACTIVE, 8'h81, "t3_active1");
        src = 8'h2A;
        repeat (3) idle();
        rd(IRQ_PENDING, 8'h2A, "t3_pend_src5");
        exp_irq(1'b0, "t3_irqb_src5");
        rd(IRQ_ACTIVE, 8'h81, "t3_active_still1");
        wr(IRQ_CLAIM, 8'h01);
        rd(IRQ_PENDING, 8'h28, "t3_pend_claim1");
        exp_irq(1'b1, "t3_irqb_nested");
        rd(IRQ_INSERVICE, 8'h0A, "t3_isr_nested");
        wr(IRQ_EOI, 8'h01);
        rd(IRQ_ACTIVE, 8'h00, "t3_active_eoi1");
        src = 8'h20;
        repeat (3) idle();
        exp_irq(1'b1, "t3_irqb_src5_held");
        rd(IRQ_PENDING, 8'h20, "t3_pend_only5");
        wr(IRQ_EOI, 8'h03);
        rd(IRQ_ACTIVE, 8'h85, "t3_active5");
        exp_irq(1'b0, "t3_irqb_src5");
        rd(IRQ_INSERVICE, 8'h00, "t3_isr_clear");
        src = 8'h00;
        wr(IRQ_ENABLE, 8'h00);
        repeat (3) idle();
        rd(IRQ_PENDING, 8'h00, "t3_pend_drained");

        // 4: W1C and new edge on the same edge
        wr(IRQ_EDGE, 8'h04);
        src = 8'h04;
        idle();
        idle();
        wr(IRQ_PENDING, 8'h04);
        rd(IRQ_PENDING, 8'h04, "t4_set_wins");
        wr(IRQ_PENDING, 8'h04);
        rd(IRQ_PENDING, 8'h00, "t4_w1c");
        src = 8'h00;
        repeat (3) idle();

        // 5: masking
        wr(IRQ_EDGE, 8'h00);
        src = 8'h40;
        repeat (3) idle();
        exp_irq(1'b1, "t5_irqb_masked");
        rd(IRQ_PENDING, 8'h40, "t5_pend_masked");
        wr(IRQ_CLAIM, 8'h06);
        rd(IRQ_INSERVICE, 8'h00, "t5_claim_ignored");
        wr(IRQ_ENABLE, 8'h40);
        exp_irq(1'b1, "t5_irqb_lag");
        rd(IRQ_ENABLE, 8'h40, "t5_enable");
        exp_irq(1'b0, "t5_irqb_unmasked");
        rd(IRQ_ACTIVE, 8'h86, "t5_active6");
        wr(IRQ_CONTROL, 8'h00);
        rd(IRQ_PENDING, 8'h40, "t5_pend_kept");
        exp_irq(1'b1, "t5_irqb_global_off");
        rd(IRQ_PENDING, 8'h40, "t5_pend_retained");
        src = 8'h00;

        // 6: NSRC=4, no synchroniser
        wr4(IRQ_EDGE, 8'h01);
        wr4(IRQ_ENABLE, 8'hFF);
        rd4(IRQ_ENABLE, 8'h0F, "t6_enable_masked");
        wr4(IRQ_CONTROL, 8'h01);
        src4 = 4'h1;
        rd4(IRQ_PENDING, 8'h00, "t6_pend_pre");
        exp_irq4(1'b1, "t6_irqb_e1");
        rd4(IRQ_PENDING, 8'h01, "t6_pend_e1");
        exp_irq4(1'b0, "t6_irqb_e2");
        rd4(IRQ_ACTIVE, 8'h80, "t6_active0");
        src4 = 4'hF;
        wr4(IRQ_EDGE, 8'h00);
        rd4(IRQ_PENDING, 8'h0F, "t6_pend_all");
        wr4(IRQ_CLAIM, 8'h07);
        rd4(IRQ_INSERVICE, 8'h00, "t6_claim7_ignored");
        wr4(IRQ_EDGE, 8'hFF);
        rd4(IRQ_EDGE, 8'h0F, "t6_edge_masked");

        idle();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
